// File: rtl/pad_ctrl_pkg.sv
// Shared definitions for the pad controller: register indices, reset
// constants and the bus FSM state type.
package pad_ctrl_pkg;

  localparam int BUS_AW = 4;
  localparam int BUS_DW = 32;

  typedef enum logic [BUS_AW-1:0] {
    REG_OUT     = 4'd0,
    REG_OE      = 4'd1,
    REG_IE      = 4'd2,
    REG_CS      = 4'd3,
    REG_SL      = 4'd4,
    REG_PU      = 4'd5,
    REG_PD      = 4'd6,
    REG_IN_PU   = 4'd7,
    REG_IN_PD   = 4'd8,
    REG_IN      = 4'd9,
    REG_RISE    = 4'd10,
    REG_FALL    = 4'd11,
    REG_IRQ_EN  = 4'd12,
    REG_OUT_SET = 4'd13,
    REG_OUT_CLR = 4'd14
  } reg_idx_e;

  // Input buffers come up enabled so pin state is observable straight out of reset.
  localparam logic [BUS_DW-1:0] IE_RESET = 32'hFFFF_FFFF;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

endpackage

// File: rtl/pad_ctrl_if.sv
// Single-outstanding register bus between software-facing logic and pad_ctrl.
interface pad_ctrl_if;
  import pad_ctrl_pkg::*;

  logic              bus_valid;
  logic              bus_we;
  logic [BUS_AW-1:0] bus_addr;
  logic [BUS_DW-1:0] bus_wdata;
  logic [BUS_DW-1:0] bus_rdata;
  logic              bus_ready;

  modport master (
    output bus_valid, bus_we, bus_addr, bus_wdata,
    input  bus_rdata, bus_ready
  );

  modport slave (
    input  bus_valid, bus_we, bus_addr, bus_wdata,
    output bus_rdata, bus_ready
  );

endinterface

// File: rtl/pad_sync.sv
// Two-flop synchroniser for asynchronous pad inputs plus a previous-value
// flop, giving single-cycle rise/fall strobes in the core clock domain.
module pad_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync = sync_q;
  assign rise = sync_q & ~prev_q;
  assign fall = ~sync_q & prev_q;

endmodule

// File: rtl/pad_ctrl.sv
// Memory-mapped pad controller: per-pad control registers, synchronised pad
// inputs with edge flags, and a level interrupt, behind a two-state bus FSM.
module pad_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_INPUT_PADS = 7,
  parameter int NUM_BIDIR_PADS = 18
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pad_ctrl_if.slave                 bus,
  output logic                      irq,
  input  logic [NUM_INPUT_PADS-1:0] input_in,
  output logic [NUM_INPUT_PADS-1:0] input_pu,
  output logic [NUM_INPUT_PADS-1:0] input_pd,
  input  logic [NUM_BIDIR_PADS-1:0] bidir_in,
  output logic [NUM_BIDIR_PADS-1:0] bidir_out,
  output logic [NUM_BIDIR_PADS-1:0] bidir_oe,
  output logic [NUM_BIDIR_PADS-1:0] bidir_cs,
  output logic [NUM_BIDIR_PADS-1:0] bidir_sl,
  output logic [NUM_BIDIR_PADS-1:0] bidir_ie,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pu,
  output logic [NUM_BIDIR_PADS-1:0] bidir_pd
);

  localparam int NI = NUM_INPUT_PADS;
  localparam int NB = NUM_BIDIR_PADS;
  localparam int NS = NB + NI;

  logic [NB-1:0] out_q, oe_q, ie_q, cs_q, sl_q, pu_q, pd_q;
  logic [NI-1:0] in_pu_q, in_pd_q;
  logic [NS-1:0] rise_q, rise_d, fall_q, fall_d, irq_en_q;
  logic          irq_q;

  bus_state_e        state_q;
  logic              ready_q;
  logic [BUS_DW-1:0] rdata_q;
  logic [BUS_DW-1:0] rd_data;

  logic [NS-1:0] in_sync, edge_rise, edge_fall;
  logic [NS-1:0] rise_clr, fall_clr;
  logic          wr_en;
  logic [NB-1:0] wdata_b;
  logic [NI-1:0] wdata_i;
  logic [NS-1:0] wdata_s;

  // Bidir pads occupy the low bits of IN/RISE/FALL/IRQ_EN, input pads above them.
  pad_sync #(.WIDTH(NS)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  ({input_in, bidir_in}),
    .sync (in_sync),
    .rise (edge_rise),
    .fall (edge_fall)
  );

  assign wr_en   = (state_q == ST_IDLE) && bus.bus_valid && bus.bus_we;
  assign wdata_b = bus.bus_wdata[NB-1:0];
  assign wdata_i = bus.bus_wdata[NI-1:0];
  assign wdata_s = bus.bus_wdata[NS-1:0];

  generate
    if (NS < BUS_DW) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^bus.bus_wdata[BUS_DW-1:NS];
    end
  endgenerate

  // A new edge wins over a same-cycle write-1-to-clear of the same bit.
  assign rise_clr = (wr_en && bus.bus_addr == REG_RISE) ? wdata_s : '0;
  assign fall_clr = (wr_en && bus.bus_addr == REG_FALL) ? wdata_s : '0;
  assign rise_d   = (rise_q & ~rise_clr) | edge_rise;
  assign fall_d   = (fall_q & ~fall_clr) | edge_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q    <= '0;
      oe_q     <= '0;
      ie_q     <= IE_RESET[NB-1:0];
      cs_q     <= '0;
      sl_q     <= '0;
      pu_q     <= '0;
      pd_q     <= '0;
      in_pu_q  <= '0;
      in_pd_q  <= '0;
      irq_en_q <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
      irq_q  <= |((rise_q | fall_q) & irq_en_q);
      if (wr_en) begin
        case (bus.bus_addr)
          REG_OUT:     out_q    <= wdata_b;
          REG_OE:      oe_q     <= wdata_b;
          REG_IE:      ie_q     <= wdata_b;
          REG_CS:      cs_q     <= wdata_b;
          REG_SL:      sl_q     <= wdata_b;
          REG_PU:      pu_q     <= wdata_b;
          REG_PD:      pd_q     <= wdata_b;
          REG_IN_PU:   in_pu_q  <= wdata_i;
          REG_IN_PD:   in_pd_q  <= wdata_i;
          REG_IRQ_EN:  irq_en_q <= wdata_s;
          REG_OUT_SET: out_q    <= out_q | wdata_b;
          REG_OUT_CLR: out_q    <= out_q & ~wdata_b;
          default:     ;
        endcase
      end
    end
  end

  // Flags are read from the registered copy, i.e. before any same-cycle set.
  always_comb begin
    rd_data = '0;
    case (bus.bus_addr)
      REG_OUT:    rd_data[NB-1:0] = out_q;
      REG_OE:     rd_data[NB-1:0] = oe_q;
      REG_IE:     rd_data[NB-1:0] = ie_q;
      REG_CS:     rd_data[NB-1:0] = cs_q;
      REG_SL:     rd_data[NB-1:0] = sl_q;
      REG_PU:     rd_data[NB-1:0] = pu_q;
      REG_PD:     rd_data[NB-1:0] = pd_q;
      REG_IN_PU:  rd_data[NI-1:0] = in_pu_q;
      REG_IN_PD:  rd_data[NI-1:0] = in_pd_q;
      REG_IN:     rd_data[NS-1:0] = in_sync;
      REG_RISE:   rd_data[NS-1:0] = rise_q;
      REG_FALL:   rd_data[NS-1:0] = fall_q;
      REG_IRQ_EN: rd_data[NS-1:0] = irq_en_q;
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (bus.bus_valid) begin
            rdata_q <= rd_data;
            ready_q <= 1'b1;
            state_q <= ST_RESP;
          end
        end
        ST_RESP: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.bus_ready = ready_q;
  assign bus.bus_rdata = rdata_q;
  assign irq           = irq_q;
  assign input_pu      = in_pu_q;
  assign input_pd      = in_pd_q;
  assign bidir_out     = out_q;
  assign bidir_oe      = oe_q;
  assign bidir_cs      = cs_q;
  assign bidir_sl      = sl_q;
  assign bidir_ie      = ie_q;
  assign bidir_pu      = pu_q;
  assign bidir_pd      = pd_q;

endmodule

// File: tb/tb_pad_ctrl.sv
// Directed self-checking bench for pad_ctrl: register access, set/clear
// aliases, pin latency, edge flags, interrupt and mid-transaction reset.
module tb_pad_ctrl;
  import pad_ctrl_pkg::*;

  localparam int NI = 7;
  localparam int NB = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          irq;
  logic [NI-1:0] input_in, input_pu, input_pd;
  logic [NB-1:0] bidir_in, bidir_out, bidir_oe, bidir_cs, bidir_sl;
  logic [NB-1:0] bidir_ie, bidir_pu, bidir_pd;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] rd;

  always #5 clk = ~clk;

  pad_ctrl_if bus_if ();

  pad_ctrl #(.NUM_INPUT_PADS(NI), .NUM_BIDIR_PADS(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .irq      (irq),
    .input_in (input_in),
    .input_pu (input_pu),
    .input_pd (input_pd),
    .bidir_in (bidir_in),
    .bidir_out(bidir_out),
    .bidir_oe (bidir_oe),
    .bidir_cs (bidir_cs),
    .bidir_sl (bidir_sl),
    .bidir_ie (bidir_ie),
    .bidir_pu (bidir_pu),
    .bidir_pd (bidir_pd)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Call at a negedge; accepted at the next posedge, returns at the negedge two cycles on.
  task automatic xfer(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wdata;
    @(posedge clk); #1;
    check("ready_pulse", 32'(bus_if.bus_ready), 32'h1);
    rdata = bus_if.bus_rdata;
    @(posedge clk); #1;
    check("ready_drop", 32'(bus_if.bus_ready), 32'h0);
    bus_if.bus_valid = 1'b0;
    bus_if.bus_we    = 1'b0;
    @(negedge clk);
    $display("xfer we=%0d addr=%0d wdata=0x%08h rdata=0x%08h", we, addr, wdata, rdata);
  endtask

  initial begin
    bus_if.bus_valid = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
    input_in = '0;
    bidir_in = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("rst_ie",    32'(bidir_ie), 32'h0003_FFFF);
    check("rst_oe",    32'(bidir_oe), 32'h0);
    check("rst_out",   32'(bidir_out), 32'h0);
    check("rst_pu",    32'({input_pu, bidir_pu}), 32'h0);
    check("rst_pd",    32'({input_pd, bidir_pd}), 32'h0);
    check("rst_cssl",  32'({bidir_cs, bidir_sl}), 32'h0);
    check("rst_irq",   32'(irq), 32'h0);
    check("rst_ready", 32'(bus_if.bus_ready), 32'h0);
    check("rst_rdata", bus_if.bus_rdata, 32'h0);
    xfer(1'b0, REG_IE, 32'h0, rd);
    check("rd_ie", rd, 32'h0003_FFFF);

    // Plain register write and read-back
    xfer(1'b1, REG_OE, 32'h0000_0005, rd);
    check("pad_oe", 32'(bidir_oe), 32'h5);
    xfer(1'b0, REG_OE, 32'h0, rd);
    check("rd_oe", rd, 32'h5);

    // OUT with set/clear aliases
    xfer(1'b1, REG_OUT, 32'h0000_00F0, rd);
    xfer(1'b1, REG_OUT_SET, 32'h0000_0003, rd);
    check("pad_out_set", 32'(bidir_out), 32'hF3);
    xfer(1'b1, REG_OUT_CLR, 32'h0000_0010, rd);
    check("pad_out_clr", 32'(bidir_out), 32'hE3);
    xfer(1'b0, REG_OUT_SET, 32'h0, rd);
    check("rd_out_set", rd, 32'h0);
    xfer(1'b0, REG_OUT_CLR, 32'h0, rd);
    check("rd_out_clr", rd, 32'h0);
    xfer(1'b0, REG_OUT, 32'h0, rd);
    check("rd_out", rd, 32'hE3);

    // Other controls, unimplemented bits, read-only IN and index 15
    xfer(1'b1, REG_CS, 32'hFFFD_5555, rd);
    check("pad_cs", 32'(bidir_cs), 32'h1_5555);
    xfer(1'b1, REG_SL, 32'h0002_AAAA, rd);
    check("pad_sl", 32'(bidir_sl), 32'h2_AAAA);
    xfer(1'b1, REG_PU, 32'h0000_0003, rd);
    xfer(1'b1, REG_PD, 32'h0003_0000, rd);
    check("pad_pupd", 32'({bidir_pu, bidir_pd}), 32'({18'h3, 18'h3_0000}));
    xfer(1'b1, REG_IN_PU, 32'hFFFF_FFFF, rd);
    check("pad_in_pu", 32'(input_pu), 32'h7F);
    xfer(1'b1, REG_IN_PD, 32'h0000_0041, rd);
    check("pad_in_pd", 32'(input_pd), 32'h41);
    xfer(1'b0, REG_IN_PU, 32'h0, rd);
    check("rd_in_pu", rd, 32'h7F);
    xfer(1'b1, REG_IN, 32'hFFFF_FFFF, rd);
    xfer(1'b0, REG_IN, 32'h0, rd);
    check("rd_in_ro", rd, 32'h0);
    xfer(1'b1, 4'd15, 32'hFFFF_FFFF, rd);
    xfer(1'b0, 4'd15, 32'h0, rd);
    check("rd_idx15", rd, 32'h0);

    // Input pad 0 rise with its interrupt enabled (bit 18)
    xfer(1'b1, REG_IRQ_EN, 32'h0004_0000, rd);
    xfer(1'b0, REG_IRQ_EN, 32'h0, rd);
    check("rd_irq_en", rd, 32'h0004_0000);
    input_in[0] = 1'b1;
    xfer(1'b0, REG_IN, 32'h0, rd);
    check("in_lat1", rd, 32'h0);
    check("irq_early", 32'(irq), 32'h0);
    xfer(1'b0, REG_IN, 32'h0, rd);
    check("in_lat2", rd, 32'h0004_0000);
    check("irq_set", 32'(irq), 32'h1);
    xfer(1'b0, REG_RISE, 32'h0, rd);
    check("rd_rise18", rd, 32'h0004_0000);
    xfer(1'b0, REG_FALL, 32'h0, rd);
    check("rd_fall0", rd, 32'h0);
    xfer(1'b1, REG_RISE, 32'h0004_0000, rd);
    check("irq_clr", 32'(irq), 32'h0);

    // Bidir pad 3 edge lands on the same edge as a W1C of RISE bit 3
    bidir_in[3] = 1'b1;
    xfer(1'b0, REG_RISE, 32'h0, rd);
    check("rise3_pre", rd, 32'h0);
    xfer(1'b1, REG_RISE, 32'h0000_0008, rd);
    xfer(1'b0, REG_RISE, 32'h0, rd);
    check("rise3_setwins", rd, 32'h0000_0008);
    xfer(1'b1, REG_RISE, 32'h0000_0008, rd);
    xfer(1'b0, REG_RISE, 32'h0, rd);
    check("rise3_w1c", rd, 32'h0);
    check("irq_masked", 32'(irq), 32'h0);

    // Reset asserted while in RESP aborts the transaction
    input_in = '0;
    bidir_in = '0;
    repeat (5) @(negedge clk);
    bus_if.bus_valid = 1'b1;
    bus_if.bus_we    = 1'b1;
    bus_if.bus_addr  = REG_OE;
    bus_if.bus_wdata = 32'h0000_00FF;
    @(posedge clk); #1;
    check("rr_ready", 32'(bus_if.bus_ready), 32'h1);
    check("rr_oe_ff", 32'(bidir_oe), 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check("rr_ready_drop", 32'(bus_if.bus_ready), 32'h0);
    check("rr_oe_rst", 32'(bidir_oe), 32'h0);
    check("rr_out_rst", 32'(bidir_out), 32'h0);
    check("rr_ie_rst", 32'(bidir_ie), 32'h0003_FFFF);
    check("rr_irq_rst", 32'(irq), 32'h0);
    bus_if.bus_valid = 1'b0;
    bus_if.bus_we    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(1'b0, REG_OE, 32'h0, rd);
    check("rr_rd_oe", rd, 32'h0);
    xfer(1'b0, REG_FALL, 32'h0, rd);
    check("rr_rd_fall", rd, 32'h0);
    xfer(1'b0, REG_IRQ_EN, 32'h0, rd);
    check("rr_rd_irq_en", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
